// File: rtl/ethercat_fmmu_multi.sv
// ethercat_fmmu_multi: maps logical-addressed EtherCAT datagram bytes onto a physical byte bus
// through NUM_FMMU channels. Define FMMU_OVERLAP_DET_EN to build the multi-hit overlap detector.
module ethercat_fmmu_multi #(
  parameter int NUM_FMMU = 4,
  parameter int PADDR_W  = 16
) (
  input  logic                         rxc,
  input  logic                         RSTN,
  input  logic                         dg_start,
  input  logic [7:0]                   dg_cmd,
  input  logic [31:0]                  dg_laddr,
  input  logic [15:0]                  dg_len,
  input  logic                         dg_byte_valid,
  input  logic [7:0]                   dg_byte_in,
  input  logic                         dg_end,
  input  logic [15:0]                  wkc_in,
  output logic [7:0]                   dg_byte_out,
  output logic                         dg_byte_out_valid,
  output logic [15:0]                  wkc_out,
  output logic                         wkc_valid,
  output logic [PADDR_W-1:0]           bus_address,
  output logic                         bus_rd,
  output logic                         bus_wr,
  output logic [7:0]                   bus_data_out,
  input  logic [7:0]                   bus_data_in,
  input  logic [32*NUM_FMMU-1:0]       cfg_lstart,
  input  logic [16*NUM_FMMU-1:0]       cfg_len,
  input  logic [PADDR_W*NUM_FMMU-1:0]  cfg_pstart,
  input  logic [2*NUM_FMMU-1:0]        cfg_type,
  input  logic [NUM_FMMU-1:0]          cfg_en,
  input  logic                         overlap_clr,
  output logic                         overlap_err
);

  localparam logic [7:0] CMD_LRD = 8'h0A;
  localparam logic [7:0] CMD_LWR = 8'h0B;
  localparam logic [7:0] CMD_LRW = 8'h0C;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

  state_t               state, state_nxt;
  logic                 drain_cnt;
  logic [7:0]           cmd_q;
  logic [31:0]          laddr_q;
  logic [15:0]          len_q, offset_q;
  logic                 rd_any_q, wr_any_q;
  logic                 is_logical, map_en, any_hit, rd_now, wr_now, end_now;
  logic [31:0]          a, sel_lstart;
  logic [PADDR_W-1:0]   sel_pstart, addr_nxt;
  logic [1:0]           sel_type;
  logic [NUM_FMMU-1:0]  hit;
  logic [7:0]           byte_p0;
  logic                 vld_p0;
  logic [15:0]          wkc_p0;
  logic                 wkc_vld_p0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  // A new header always restarts, which aborts whatever datagram was open.
  always_comb begin
    state_nxt = state;
    end_now   = 1'b0;
    case (state)
      IDLE:   if (dg_start) state_nxt = ACTIVE;
      ACTIVE: begin
        if (dg_start) state_nxt = ACTIVE;
        else if (dg_end) begin
          state_nxt = DRAIN;
          end_now   = 1'b1;
        end
      end
      DRAIN: begin
        if (dg_start)       state_nxt = ACTIVE;
        else if (drain_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN)                           drain_cnt <= 1'b0;
    else if (state == DRAIN && !dg_start) drain_cnt <= ~drain_cnt;
    else                                 drain_cnt <= 1'b0;
  end

  assign is_logical = (cmd_q == CMD_LRD) || (cmd_q == CMD_LWR) || (cmd_q == CMD_LRW);
  assign map_en     = (state == ACTIVE) && dg_byte_valid && !dg_start && is_logical &&
                      (offset_q < len_q);
  assign a          = laddr_q + {16'd0, offset_q};

  // Window compare is done in 33 bits so a channel near the top of the space cannot wrap.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_FMMU; i++) begin
      hit[i] = map_en && cfg_en[i] &&
               ({1'b0, a} >= {1'b0, cfg_lstart[32*i +: 32]}) &&
               ({1'b0, a} < ({1'b0, cfg_lstart[32*i +: 32]} + {17'd0, cfg_len[16*i +: 16]}));
    end
  end

  always_comb begin
    any_hit    = 1'b0;
    sel_lstart = '0;
    sel_pstart = '0;
    sel_type   = '0;
    for (int i = NUM_FMMU - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit    = 1'b1;
        sel_lstart = cfg_lstart[32*i +: 32];
        sel_pstart = cfg_pstart[PADDR_W*i +: PADDR_W];
        sel_type   = cfg_type[2*i +: 2];
      end
    end
  end

  assign addr_nxt = sel_pstart + PADDR_W'(a - sel_lstart);
  assign rd_now   = any_hit && sel_type[0] && ((cmd_q == CMD_LRD) || (cmd_q == CMD_LRW));
  assign wr_now   = any_hit && sel_type[1] && ((cmd_q == CMD_LWR) || (cmd_q == CMD_LRW));

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      cmd_q    <= '0;
      laddr_q  <= '0;
      len_q    <= '0;
      offset_q <= '0;
      rd_any_q <= 1'b0;
      wr_any_q <= 1'b0;
    end else if (dg_start) begin
      cmd_q    <= dg_cmd;
      laddr_q  <= dg_laddr;
      len_q    <= dg_len;
      offset_q <= '0;
      rd_any_q <= 1'b0;
      wr_any_q <= 1'b0;
    end else if (state == ACTIVE && dg_byte_valid) begin
      offset_q <= sat_inc(offset_q);
      rd_any_q <= rd_any_q | rd_now;
      wr_any_q <= wr_any_q | wr_now;
    end
  end

  // Stage p0: bus access strobes and the byte carried alongside them.
  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      bus_rd       <= 1'b0;
      bus_wr       <= 1'b0;
      bus_address  <= '0;
      bus_data_out <= '0;
      vld_p0       <= 1'b0;
      byte_p0      <= '0;
    end else begin
      bus_rd <= rd_now;
      bus_wr <= wr_now;
      vld_p0 <= dg_byte_valid;
      if (any_hit)       bus_address  <= addr_nxt;
      if (wr_now)        bus_data_out <= dg_byte_in;
      if (dg_byte_valid) byte_p0      <= dg_byte_in;
    end
  end

  // Stage p1: read data replaces the frame byte only when a read strobe was issued.
  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      dg_byte_out_valid <= 1'b0;
      dg_byte_out       <= '0;
    end else begin
      dg_byte_out_valid <= vld_p0;
      if (vld_p0) dg_byte_out <= bus_rd ? bus_data_in : byte_p0;
    end
  end

  // Working counter: computed at dg_end, presented one cycle later unless a new header aborts it.
  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      wkc_vld_p0 <= 1'b0;
      wkc_p0     <= '0;
      wkc_valid  <= 1'b0;
      wkc_out    <= '0;
    end else begin
      wkc_vld_p0 <= end_now;
      if (end_now)
        wkc_p0 <= is_logical ? wkc_in + {14'd0, wr_any_q | wr_now, rd_any_q | rd_now} : wkc_in;
      wkc_valid <= wkc_vld_p0 && !dg_start;
      if (wkc_vld_p0) wkc_out <= wkc_p0;
    end
  end

`ifdef FMMU_OVERLAP_DET_EN
  logic multi_hit, seen_hit;

  always_comb begin
    multi_hit = 1'b0;
    seen_hit  = 1'b0;
    for (int i = 0; i < NUM_FMMU; i++) begin
      if (hit[i]) begin
        if (seen_hit) multi_hit = 1'b1;
        seen_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN)            overlap_err <= 1'b0;
    else if (multi_hit)   overlap_err <= 1'b1;
    else if (overlap_clr) overlap_err <= 1'b0;
  end
`else
  logic unused_overlap_clr;
  assign unused_overlap_clr = overlap_clr;
  assign overlap_err        = 1'b0;
`endif

endmodule
